// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty-flag synchronizer and first-word-fall-through output
// stage for an asynchronous-comparison FIFO. Everything here runs on rclk.
module rptr_empty_fwft #(
    parameter int DSIZE    = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                aempty_n,
    output logic [ADDRSIZE-1:0] rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                ren,
    input  logic [DSIZE-1:0]    rmem_data,
    output logic [DSIZE-1:0]    rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rempty
);

    logic                rempty2;
    logic [ADDRSIZE-1:0] rbin;
    logic [ADDRSIZE-1:0] rbnext;
    logic [ADDRSIZE-1:0] rgnext;
    logic [1:0]          cnt;
    logic [1:0]          cnt_next;
    logic                inflight;
    logic                pop;
    logic [2:0]          demand;
    logic [1:0]          wr_idx;
    logic [DSIZE-1:0]    head;
    logic [DSIZE-1:0]    tail;
    logic [DSIZE-1:0]    head_next;
    logic [DSIZE-1:0]    tail_next;

    // Falling aempty_n sets the flag immediately; its release is seen two edges
    // later. In the clocked branch aempty_n is known to be high, hence the 0.
    always_ff @(posedge rclk or negedge rrst_n or negedge aempty_n) begin
        if (!rrst_n || !aempty_n) begin
            rempty  <= 1'b1;
            rempty2 <= 1'b1;
        end else begin
            rempty  <= rempty2;
            rempty2 <= 1'b0;
        end
    end

    assign pop    = rvalid & rready;
    // Words owned by the stage after this edge: buffered plus in flight, less
    // the one leaving now. Fetch only while that leaves room for another.
    assign demand = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    assign ren    = ~rempty & (demand < 3'd2);

    assign rbnext = rbin + {{(ADDRSIZE-1){1'b0}}, ren};
    assign rgnext = (rbnext >> 1) ^ rbnext;
    assign raddr  = rbin;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin <= '0;
            rptr <= '0;
        end else begin
            rbin <= rbnext;
            rptr <= rgnext;
        end
    end

    assign cnt_next = cnt + {1'b0, inflight} - {1'b0, pop};
    assign wr_idx   = cnt - {1'b0, pop};

    // The head only shifts when a second word is queued behind it, so rdata
    // keeps its last value once the buffer drains.
    always_comb begin
        head_next = head;
        tail_next = tail;
        if (pop && (cnt == 2'd2)) begin
            head_next = tail;
        end
        if (inflight) begin
            if (wr_idx == 2'd0) begin
                head_next = rmem_data;
            end else begin
                tail_next = rmem_data;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            rvalid   <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            cnt      <= cnt_next;
            inflight <= ren;
            rvalid   <= (cnt_next != 2'd0);
            head     <= head_next;
            tail     <= tail_next;
        end
    end

    assign rdata = head;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: a registered-read RAM model plus word-count
// bookkeeping that predicts flags, pointer values and delivered data.
module tb_rptr_empty_fwft;

    localparam int DSIZE    = 8;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 16;

    logic                rclk      = 1'b0;
    logic                rrst_n    = 1'b0;
    logic                aempty_n  = 1'b0;
    logic                rready    = 1'b0;
    logic [DSIZE-1:0]    rmem_data = '0;
    logic                ren;
    logic                rvalid;
    logic                rempty;
    logic [ADDRSIZE-1:0] rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [DSIZE-1:0]    rdata;

    logic [DSIZE-1:0] mem [DEPTH];

    int checks = 0;
    int passed = 0;

    // Words requested (ren at an edge), requested as of one edge earlier, and
    // words handed to the consumer.
    int fetched;
    int fetched_d1;
    int popped;

    rptr_empty_fwft #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .aempty_n  (aempty_n),
        .rptr      (rptr),
        .raddr     (raddr),
        .ren       (ren),
        .rmem_data (rmem_data),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rempty    (rempty)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (ren) rmem_data <= mem[raddr];
    end

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            fetched    <= 0;
            fetched_d1 <= 0;
            popped     <= 0;
        end else begin
            fetched_d1 <= fetched;
            if (ren) fetched <= fetched + 1;
            if (rvalid && rready) popped <= popped + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDRSIZE-1:0] gray(input int b);
        logic [ADDRSIZE-1:0] v;
        v = b[ADDRSIZE-1:0];
        return v ^ (v >> 1);
    endfunction

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset;
        rrst_n   = 1'b0;
        aempty_n = 1'b0;
        rready   = 1'b0;
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
    endtask

    task automatic fill_seq;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);
    endtask

    task automatic fill_rand;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset;
        do_reset();
        aempty_n = 1'b1;
        repeat (8) tick();
        #3;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0) $display("FAIL reset_precond rvalid/rdata got=%0b/%h exp=1/a0", rvalid, rdata); else passed++;
        checks++; if (fetched - popped !== 2) $display("FAIL reset_precond_words got=%0d exp=2", fetched - popped); else passed++;
        rrst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%0b exp=0", rvalid); else passed++;
        checks++; if (rempty !== 1'b1) $display("FAIL reset_rempty got=%0b exp=1", rempty); else passed++;
        checks++; if (rptr !== 4'd0) $display("FAIL reset_rptr got=%b exp=0000", rptr); else passed++;
        checks++; if (raddr !== 4'd0) $display("FAIL reset_raddr got=%0d exp=0", raddr); else passed++;
        checks++; if (ren !== 1'b0) $display("FAIL reset_ren got=%0b exp=0", ren); else passed++;
        checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", rdata); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_empty_release;
        do_reset();
        rready   = 1'b1;
        aempty_n = 1'b1;
        tick(); #3;
        checks++; if (rempty !== 1'b1 || ren !== 1'b0) $display("FAIL release_e1 rempty/ren got=%0b/%0b exp=1/0", rempty, ren); else passed++;
        tick(); #3;
        checks++; if (rempty !== 1'b0 || ren !== 1'b1) $display("FAIL release_e2 rempty/ren got=%0b/%0b exp=0/1", rempty, ren); else passed++;
        checks++; if (rptr !== 4'b0000) $display("FAIL release_rptr0 got=%b exp=0000", rptr); else passed++;
        tick(); #3;
        checks++; if (rptr !== 4'b0001 || rvalid !== 1'b0) $display("FAIL release_e3 rptr/rvalid got=%b/%0b exp=0001/0", rptr, rvalid); else passed++;
        tick(); #3;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0) $display("FAIL release_first_word rvalid/rdata got=%0b/%h exp=1/a0", rvalid, rdata); else passed++;
        aempty_n = 1'b0;
        repeat (4) tick();
        $display("test_empty_release done");
    endtask

    task automatic test_backpressure;
        int pulses;
        pulses = 0;
        do_reset();
        aempty_n = 1'b1;
        repeat (12) begin
            tick(); #3;
            if (ren) pulses++;
        end
        checks++; if (pulses !== 2) $display("FAIL bp_ren_pulses got=%0d exp=2", pulses); else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0 || ren !== 1'b0) $display("FAIL bp_hold%0d rvalid/rdata/ren got=%0b/%h/%0b exp=1/a0/0", k, rvalid, rdata, ren); else passed++;
            tick(); #3;
        end
        rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rvalid !== 1'b1 || rdata !== 8'(8'hA0 + k)) $display("FAIL bp_drain%0d rvalid/rdata got=%0b/%h exp=1/%h", k, rvalid, rdata, 8'(8'hA0 + k)); else passed++;
            tick(); #3;
        end
        aempty_n = 1'b0;
        repeat (4) tick();
        $display("test_backpressure done");
    endtask

    task automatic test_async_empty;
        int extra;
        extra = 0;
        do_reset();
        rready   = 1'b1;
        aempty_n = 1'b1;
        tick(); tick(); #3;
        checks++; if (ren !== 1'b1) $display("FAIL async_first_ren got=%0b exp=1", ren); else passed++;
        tick(); #1;
        checks++; if (ren !== 1'b1 || fetched !== 1) $display("FAIL async_pre ren/fetched got=%0b/%0d exp=1/1", ren, fetched); else passed++;
        aempty_n = 1'b0;
        #1;
        checks++; if (rempty !== 1'b1 || ren !== 1'b0) $display("FAIL async_no_edge rempty/ren got=%0b/%0b exp=1/0", rempty, ren); else passed++;
        tick(); #3;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0) $display("FAIL async_inflight_word rvalid/rdata got=%0b/%h exp=1/a0", rvalid, rdata); else passed++;
        repeat (5) begin
            if (ren) extra++;
            tick(); #3;
        end
        checks++; if (extra !== 0) $display("FAIL async_extra_ren got=%0d exp=0", extra); else passed++;
        checks++; if (popped !== 1 || fetched !== 1 || rvalid !== 1'b0) $display("FAIL async_totals popped/fetched/rvalid got=%0d/%0d/%0b exp=1/1/0", popped, fetched, rvalid); else passed++;
        $display("test_async_empty done");
    endtask

    task automatic test_simul_write_pop;
        do_reset();
        rready   = 1'b1;
        aempty_n = 1'b1;
        repeat (4) tick();
        #3;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0 || ren !== 1'b1) $display("FAIL simul_pre rvalid/rdata/ren got=%0b/%h/%0b exp=1/a0/1", rvalid, rdata, ren); else passed++;
        tick(); #3;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA1) $display("FAIL simul_shift rvalid/rdata got=%0b/%h exp=1/a1", rvalid, rdata); else passed++;
        checks++; if (fetched_d1 - popped !== 1) $display("FAIL simul_occupancy got=%0d exp=1", fetched_d1 - popped); else passed++;
        aempty_n = 1'b0;
        repeat (4) tick();
        $display("test_simul_write_pop done");
    endtask

    task automatic test_wrap;
        logic [ADDRSIZE-1:0] prev;
        bit wrapped;
        int errs;
        wrapped = 1'b0;
        errs    = 0;
        prev    = '0;
        do_reset();
        rready   = 1'b1;
        aempty_n = 1'b1;
        repeat (26) begin
            tick(); #3;
            checks++; if (rptr !== gray(fetched) || raddr !== 4'(fetched % DEPTH)) begin $display("FAIL wrap_ptr rptr/raddr got=%b/%0d exp=%b/%0d", rptr, raddr, gray(fetched), fetched % DEPTH); errs++; end else passed++;
            if (rvalid) begin
                checks++; if (rdata !== mem[popped % DEPTH]) $display("FAIL wrap_data idx=%0d got=%h exp=%h", popped, rdata, mem[popped % DEPTH]); else passed++;
            end
            if (prev == 4'd15 && raddr == 4'd0) wrapped = 1'b1;
            prev = raddr;
        end
        checks++; if (!wrapped || fetched < 20) $display("FAIL wrap_seen wrapped/fetched got=%0b/%0d exp=1/>=20", wrapped, fetched); else passed++;
        aempty_n = 1'b0;
        repeat (4) tick();
        $display("test_wrap done fetched=%0d errors=%0d", fetched, errs);
    endtask

    task automatic test_random;
        int  run;
        bit  exp_rempty;
        bit  exp_rvalid;
        bit  exp_ren;
        int  errs;
        run  = 0;
        errs = 0;
        do_reset();
        repeat (400) begin
            @(posedge rclk);
            run = aempty_n ? run + 1 : 0;
            #1;
            rready = ($urandom_range(0, 3) != 0);
            if (aempty_n) begin
                if ($urandom_range(0, 19) == 0) aempty_n = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) aempty_n = 1'b1;
            end
            if (!aempty_n) run = 0;
            #3;
            exp_rempty = !(aempty_n && run >= 2);
            exp_rvalid = (fetched_d1 > popped);
            exp_ren    = !exp_rempty && ((fetched - popped - int'(exp_rvalid && rready)) < 2);
            checks++; if (rempty !== exp_rempty) begin $display("FAIL rand_rempty got=%0b exp=%0b", rempty, exp_rempty); errs++; end else passed++;
            checks++; if (rvalid !== exp_rvalid) begin $display("FAIL rand_rvalid got=%0b exp=%0b", rvalid, exp_rvalid); errs++; end else passed++;
            checks++; if (ren !== exp_ren) begin $display("FAIL rand_ren got=%0b exp=%0b", ren, exp_ren); errs++; end else passed++;
            checks++; if (rptr !== gray(fetched)) begin $display("FAIL rand_rptr got=%b exp=%b", rptr, gray(fetched)); errs++; end else passed++;
            if (exp_rvalid) begin
                checks++; if (rdata !== mem[popped % DEPTH]) begin $display("FAIL rand_rdata idx=%0d got=%h exp=%h", popped, rdata, mem[popped % DEPTH]); errs++; end else passed++;
            end
        end
        $display("test_random done delivered=%0d errors=%0d", popped, errs);
    endtask

    initial begin
        fill_seq();
        test_reset();
        test_empty_release();
        test_backpressure();
        test_async_empty();
        test_simul_write_pop();
        fill_rand();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rptr_empty_fwft.md
# rptr_empty_fwft

Read-side pointer and empty-flag controller for the asynchronous-comparison FIFO, with a first-word-fall-through output stage. It lives in the read clock domain. It takes the asynchronous almost-empty indication from the pointer comparator, synchronizes it into a registered `rempty` flag, and advances a binary/Gray read pointer pair. It also drives the registered-output dual-port RAM and delivers words to the consumer over a valid/ready handshake with a 2-entry output buffer.

## Interface
- `DSIZE`, default 8: data word width.
- `ADDRSIZE`, default 4: RAM address width; the FIFO depth is 2^ADDRSIZE.

Ports:
- `rclk`  in  1  read clock; the only clock in the block.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `aempty_n`  in  1  asynchronous almost-empty from the comparator, active low.
- `rptr`  out  ADDRSIZE  registered Gray read pointer, to the comparator.
- `raddr`  out  ADDRSIZE  binary read address to the RAM (the `rbin` register).
- `ren`  out  1  RAM read enable (combinational).
- `rmem_data`  in  DSIZE  RAM read data, valid the cycle after `ren`.
- `rdata`  out  DSIZE  head word of the output buffer.
- `rvalid`  out  1  `rdata` is valid.
- `rready`  in  1  consumer accepts `rdata`.
- `rempty`  out  1  registered empty flag.

## Operation
**Empty flag**
- Two flops, `rempty` and `rempty2`.
- Asynchronously set to 1,1 when `rrst_n` is 0 or when `aempty_n` is 0.
- Otherwise each edge loads {`rempty`, `rempty2`} <= {`rempty2`, ~`aempty_n`}.

**Read pointer**
- `rbnext` = `rbin` + `ren`. Wraps modulo 2^ADDRSIZE; carry is discarded.
- Gray value = (`rbnext`>>1) ^ `rbnext`.
- `rbin` and `rptr` are both registered on `rclk`.

**Fetch**
- Definitions:
  - `pop` = `rvalid` & `rready`.
  - `cnt` = output-buffer occupancy, 0..2.
  - `inflight` = registered copy of `ren`.
- `ren` = !`rempty` & ((`cnt` + `inflight` − `pop`) < 2). This guarantees the buffer never overflows.
- The cycle after `ren`, `rmem_data` is written into the buffer tail. `rdata` always shows the buffer head.

**Output buffer**
- 2-entry FIFO; words leave in RAM address order.
- `rvalid` = (`cnt` != 0), registered.
- A simultaneous write and `pop` keeps `cnt` unchanged and shifts the head.

**Boundary conditions**
- `rempty` asserting asynchronously forces `ren` to 0 at once. A read already in flight still completes and is delivered; no extra word is fetched.
- With `rready` held low, `cnt` saturates at 2, `ren` stays 0, and `rdata`/`rvalid` stay stable.
- Pointer wrap: `rbin` goes from 2^ADDRSIZE−1 to 0. For ADDRSIZE=4, the Gray value goes 1000 -> 0000.
- Reset mid-operation: buffered and in-flight words are discarded, and every register returns to its reset value.

**Reset values**
- `rptr` = 0, `raddr` = 0.
- `rempty` = 1 (and `rempty2` = 1).
- `rvalid` = 0, `rdata` = 0.
- `ren` = 0.
- `cnt` = 0, `inflight` = 0.

## Timing
- Empty release: `aempty_n` rises before edge E1. `rempty2` goes to 0 at E1 and `rempty` goes to 0 at E2. `ren` can first be 1 in the cycle after E2.
- Fetch to valid: `ren` in cycle N, data on `rmem_data` in cycle N+1, `rvalid` = 1 in cycle N+2.
- Empty release to first word: `rvalid` rises 2 cycles after `rempty` falls.
- Throughput: 1 word per cycle is sustained while `rempty` = 0 and `rready` = 1.
- `rptr` updates on the same edge that consumes `ren`.
- Empty assert: `aempty_n` falling sets `rempty` with no clock edge required.

## Test plan
1. **Reset.** Assert `rrst_n`=0 mid-run with 2 words buffered -> immediately `rvalid`=0, `rempty`=1, `rptr`=0, `raddr`=0, `ren`=0.
2. **Empty release.** RAM preloaded with 0xA0..0xA3, `aempty_n` rises, `rready`=1 -> `rempty` falls at the 2nd edge and `ren` is high that cycle. `rvalid` rises 2 cycles later with `rdata`=0xA0. `rptr` goes 0000 -> 0001.
3. **Backpressure.** 4 words available, `rready`=0 -> exactly 2 `ren` pulses, `rdata`=0xA0 held stable. Then `rready`=1 -> 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles with no gaps.
4. **Wrap-around.** 20 back-to-back reads -> `rptr` sequence 0000, 0001, 0011, 0010, 0110, …, 1000, 0000, 0001… and `raddr` goes 15 -> 0 with data in order.
5. **Async empty mid-stream.** `aempty_n` falls in the same cycle as an in-flight read -> `ren`=0 that cycle and `rempty`=1 without a clock edge. The in-flight word is still delivered; no further `ren` occurs.
6. **Simultaneous write and pop.** `cnt`=1, a returning word and `pop` land in the same cycle -> `cnt` stays 1, `rdata` advances to the next word, `rvalid` stays 1.
